// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the mem_loader command engine.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PARAM        = 3'd1,
    ST_LOAD_COLLECT = 3'd2,
    ST_LOAD_WRITE   = 3'd3,
    ST_DUMP_READ    = 3'd4,
    ST_DUMP_WAIT    = 3'd5,
    ST_DUMP_SEND    = 3'd6
  } state_t;

  localparam logic [1:0] CMD_LOAD_I = 2'b00;
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_DUMP_D = 2'b10;
  localparam logic [1:0] CMD_RUN    = 2'b11;

  localparam int BYTES_I = 4;
  localparam int BYTES_D = 8;

  // RUN carries the enable value in bit 0; every other command has an all-zero payload field.
  function automatic logic hdr_legal(input logic [7:0] h);
    if (h[7:6] == CMD_RUN) return (h[5:1] == 5'd0);
    return (h[5:0] == 6'd0);
  endfunction

endpackage

// File: rtl/mem_loader_byte_serializer.sv
// Splits a 64-bit word into 8 bytes, LSB first, over a valid/ready output.
// Handshake: a byte moves on a rising edge where o_tx_valid && i_tx_ready; data/valid hold while stalled.
module mem_loader_byte_serializer (
  input  logic        clk,
  input  logic        arst,
  input  logic        i_load,
  input  logic [63:0] i_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_done
);

  logic [63:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        r_done;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_shift <= i_data;
        r_cnt   <= '0;
        r_valid <= 1'b1;
      end else if (r_valid && i_tx_ready) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_shift <= {8'h00, r_shift[63:8]};
        end
      end
    end
  end

  assign o_tx_data  = r_shift[7:0];
  assign o_tx_valid = r_valid;
  assign o_done     = r_done;

endmodule

// File: rtl/mem_loader.sv
// Byte-stream command engine that loads imem/dmem, dumps dmem and gates the cpu enable.
// Handshakes: rx byte accepted on a rising edge with rx_valid && rx_ready; tx byte moves with tx_valid && tx_ready.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int IMEM_SHIFT = 2,
  parameter int DMEM_SHIFT = 3
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        err_cmd,
  output state_t      dbg_state
);

  state_t           r_state;
  logic             r_live;
  logic [1:0]       r_cmd;
  logic [1:0]       r_pcnt;
  logic [23:0]      r_param;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bcnt;
  logic [63:0]      r_word;
  logic             r_cpu_en;
  logic [63:0]      r_addr_i;
  logic             r_wen_i;
  logic [31:0]      r_wdata_i;
  logic [63:0]      r_addr_d;
  logic             r_wen_d;
  logic             r_ren_d;
  logic [63:0]      r_wdata_d;
  logic             r_err;

  logic [31:0]      w_param_full;
  logic [CNT_W-1:0] w_p_idx;
  logic [CNT_W-1:0] w_p_cnt;
  logic             w_is_d;
  logic             w_last_byte;
  logic [63:0]      w_word_d;
  logic [31:0]      w_word_i;
  logic [CNT_W-1:0] w_idx_inc;
  logic             w_ser_load;
  logic             w_ser_done;

  assign w_param_full = {rx_data, r_param};
  assign w_p_idx      = w_param_full[CNT_W-1:0];
  assign w_p_cnt      = w_param_full[16 +: CNT_W];
  assign w_is_d       = (r_cmd == CMD_LOAD_D);
  assign w_last_byte  = w_is_d ? (r_bcnt == 3'(BYTES_D - 1)) : (r_bcnt == 3'(BYTES_I - 1));
  // Bytes arrive LSB first and shift in from the top, so the newest byte completes the word's MSB.
  assign w_word_d     = {rx_data, r_word[63:8]};
  assign w_word_i     = {rx_data, r_word[63:40]};
  assign w_idx_inc    = r_idx + CNT_W'(1);
  assign w_ser_load   = (r_state == ST_DUMP_WAIT);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_live    <= 1'b0;
      r_cmd     <= CMD_LOAD_I;
      r_pcnt    <= '0;
      r_param   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_bcnt    <= '0;
      r_word    <= '0;
      r_cpu_en  <= 1'b0;
      r_addr_i  <= '0;
      r_wen_i   <= 1'b0;
      r_wdata_i <= '0;
      r_addr_d  <= '0;
      r_wen_d   <= 1'b0;
      r_ren_d   <= 1'b0;
      r_wdata_d <= '0;
      r_err     <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_wen_i <= 1'b0;
      r_wen_d <= 1'b0;
      r_ren_d <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rx_valid && rx_ready) begin
            if (!hdr_legal(rx_data)) begin
              r_err <= 1'b1;
            end else if (rx_data[7:6] == CMD_RUN) begin
              r_cpu_en <= rx_data[0];
            end else begin
              r_cpu_en <= 1'b0;
              r_cmd    <= rx_data[7:6];
              r_pcnt   <= '0;
              r_state  <= ST_PARAM;
            end
          end
        end
        ST_PARAM: begin
          if (rx_valid) begin
            r_param <= {rx_data, r_param[23:8]};
            r_pcnt  <= r_pcnt + 2'd1;
            if (r_pcnt == 2'd3) begin
              r_idx  <= w_p_idx;
              r_cnt  <= w_p_cnt;
              r_bcnt <= '0;
              if (w_p_cnt == '0) begin
                r_state <= ST_IDLE;
              end else if (r_cmd == CMD_DUMP_D) begin
                r_state  <= ST_DUMP_READ;
                r_ren_d  <= 1'b1;
                r_addr_d <= 64'(w_p_idx) << DMEM_SHIFT;
              end else begin
                r_state <= ST_LOAD_COLLECT;
              end
            end
          end
        end
        ST_LOAD_COLLECT: begin
          if (rx_valid) begin
            r_word <= w_word_d;
            r_bcnt <= r_bcnt + 3'd1;
            if (w_last_byte) begin
              r_bcnt  <= '0;
              r_state <= ST_LOAD_WRITE;
              if (w_is_d) begin
                r_wen_d   <= 1'b1;
                r_addr_d  <= 64'(r_idx) << DMEM_SHIFT;
                r_wdata_d <= w_word_d;
              end else begin
                r_wen_i   <= 1'b1;
                r_addr_i  <= 64'(r_idx) << IMEM_SHIFT;
                r_wdata_i <= w_word_i;
              end
            end
          end
        end
        ST_LOAD_WRITE: begin
          r_idx   <= w_idx_inc;
          r_cnt   <= r_cnt - CNT_W'(1);
          r_state <= (r_cnt == CNT_W'(1)) ? ST_IDLE : ST_LOAD_COLLECT;
        end
        ST_DUMP_READ: begin
          r_state <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          r_state <= ST_DUMP_SEND;
        end
        ST_DUMP_SEND: begin
          if (w_ser_done) begin
            r_idx <= w_idx_inc;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_state  <= ST_DUMP_READ;
              r_ren_d  <= 1'b1;
              r_addr_d <= 64'(w_idx_inc) << DMEM_SHIFT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // rdata_ext_2 is valid during DUMP_WAIT, so the serializer captures it directly that cycle.
  mem_loader_byte_serializer u_byte_serializer (
    .clk        (clk),
    .arst       (arst),
    .i_load     (w_ser_load),
    .i_data     (rdata_ext_2),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done     (w_ser_done)
  );

  // r_live keeps rx_ready low while reset is held so every output reads 0 in reset.
  assign rx_ready    = r_live && ((r_state == ST_IDLE) || (r_state == ST_PARAM) ||
                                  (r_state == ST_LOAD_COLLECT));
  assign busy        = (r_state != ST_IDLE);
  assign err_cmd     = r_err;
  assign cpu_enable  = r_cpu_en;
  assign addr_ext    = r_addr_i;
  assign wen_ext     = r_wen_i;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_i;
  assign addr_ext_2  = r_addr_d;
  assign wen_ext_2   = r_wen_d;
  assign ren_ext_2   = r_ren_d;
  assign wdata_ext_2 = r_wdata_d;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: byte driver, dmem model, strobe/tx monitors against expected queues.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk;
  logic        arst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        busy;
  logic        err_cmd;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_mis = 0;

  logic [95:0]  exp_wi_q[$];
  logic [127:0] exp_wd_q[$];
  logic [7:0]   exp_tx_q[$];

  logic [63:0] mem [16];
  bit          tx_rand = 1'b0;
  logic        tx_stall_q = 1'b0;
  logic [7:0]  tx_stall_data = 8'h00;

  mem_loader dut (
    .clk         (clk),
    .arst        (arst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2),
    .busy        (busy),
    .err_cmd     (err_cmd),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- environment: dmem model and tx sink ----------------
  always @(posedge clk) begin
    if (wen_ext_2) mem[addr_ext_2[6:3]] <= wdata_ext_2;
    if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[6:3]];
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [95:0]  e_wi;
    logic [127:0] e_wd;
    logic [7:0]   e_tx;
    if (wen_ext) begin
      check("wi_pending", 128'(exp_wi_q.size() != 0), 128'd1);
      check("wi_excl", {wen_ext_2, ren_ext_2, ren_ext, cpu_enable}, 128'd0);
      if (exp_wi_q.size() != 0) begin
        e_wi = exp_wi_q.pop_front();
        check("wi_word", {addr_ext, wdata_ext}, 128'(e_wi));
      end
    end
    if (wen_ext_2) begin
      check("wd_pending", 128'(exp_wd_q.size() != 0), 128'd1);
      check("wd_excl", {wen_ext, ren_ext_2, ren_ext, cpu_enable}, 128'd0);
      if (exp_wd_q.size() != 0) begin
        e_wd = exp_wd_q.pop_front();
        check("wd_word", {addr_ext_2, wdata_ext_2}, e_wd);
      end
    end
    if (ren_ext_2) check("rd_excl", {wen_ext, wen_ext_2, cpu_enable}, 128'd0);
    if (tx_stall_q) check("tx_stable", {tx_valid, tx_data}, {1'b1, tx_stall_data});
    if (tx_valid && tx_ready) begin
      check("tx_pending", 128'(exp_tx_q.size() != 0), 128'd1);
      if (exp_tx_q.size() != 0) begin
        e_tx = exp_tx_q.pop_front();
        check("tx_byte", tx_data, e_tx);
      end
    end
    tx_stall_q    <= tx_valid && !tx_ready;
    tx_stall_data <= tx_data;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("rx_accept", 128'(ok), 128'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] hdr, input logic [15:0] idx, input logic [15:0] n);
    send_byte(hdr);
    send_byte(idx[7:0]);
    send_byte(idx[15:8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [63:0] w, input int nbytes);
    for (int b = 0; b < nbytes; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 128'(ok), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {rx_ready, tx_valid, tx_data, cpu_enable, wen_ext, ren_ext,
                           wen_ext_2, ren_ext_2, busy, err_cmd}, 128'd0);
    check({tag, "_imem"}, {addr_ext, wdata_ext}, 128'd0);
    check({tag, "_dmem"}, {addr_ext_2, wdata_ext_2}, 128'd0);
    check({tag, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] rw [3];
    logic [63:0] ww0;
    logic [63:0] ww1;
    arst     = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    arst = 1'b0;

    // RUN enable, then reset while collecting a load word.
    send_byte(8'hC1);
    check("run_en", 128'(cpu_enable), 128'd1);
    send_cmd(8'h00, 16'd0, 16'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("mid_state", 128'(dbg_state), 128'(ST_LOAD_COLLECT));
    #2;
    arst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;

    // LOAD_I idx=2 N=2.
    exp_wi_q.push_back({64'h8, 32'h12345678});
    exp_wi_q.push_back({64'hC, 32'hDEADBEEF});
    send_cmd(8'h00, 16'd2, 16'd2);
    send_word(64'h12345678, BYTES_I);
    send_word(64'hDEADBEEF, BYTES_I);
    wait_idle("load_i_idle");

    // LOAD_D idx=1 N=1, then dump it back.
    exp_wd_q.push_back({64'h8, 64'h0807060504030201});
    send_cmd(8'h40, 16'd1, 16'd1);
    send_word(64'h0807060504030201, BYTES_D);
    wait_idle("load_d_idle");
    for (int b = 1; b <= 8; b++) exp_tx_q.push_back(8'(b));
    send_cmd(8'h80, 16'd1, 16'd1);
    wait_idle("dump1_idle");

    // Random words at idx 4..6, dumped with a randomly stalling sink.
    for (int k = 0; k < 3; k++) begin
      rw[k] = {$urandom, $urandom};
      exp_wd_q.push_back({64'((4 + k) * 8), rw[k]});
    end
    send_cmd(8'h40, 16'd4, 16'd3);
    for (int k = 0; k < 3; k++) send_word(rw[k], BYTES_D);
    wait_idle("load_r_idle");
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 8; b++) exp_tx_q.push_back(rw[k][8*b +: 8]);
    tx_rand = 1'b1;
    send_cmd(8'h80, 16'd4, 16'd3);
    wait_idle("dump_r_idle");
    tx_rand = 1'b0;

    // Illegal headers, RUN, and LOAD forcing the cpu off.
    send_byte(8'h05);
    check("err_05", {err_cmd, busy}, 128'b10);
    @(posedge clk);
    #1;
    check("err_05_clr", 128'(err_cmd), 128'd0);
    send_byte(8'hC3);
    check("err_c3", {err_cmd, cpu_enable}, 128'b10);
    send_byte(8'h41);
    check("err_41", {err_cmd, busy}, 128'b10);
    send_byte(8'hC1);
    check("run_c1", {cpu_enable, err_cmd}, 128'b10);
    send_byte(8'h00);
    check("load_cpu_off", {cpu_enable, busy}, 128'b01);
    exp_wi_q.push_back({64'h0, 32'hCAFEF00D});
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(64'hCAFEF00D, BYTES_I);
    wait_idle("cpu_off_idle");

    // N=0: straight back to IDLE after the parameters, no write.
    send_byte(8'h40);
    check("n0_busy_hdr", 128'(busy), 128'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("n0_busy_done", 128'(busy), 128'd0);

    // Index wrap from 0xFFFF to 0.
    ww0 = {$urandom, $urandom};
    ww1 = {$urandom, $urandom};
    exp_wd_q.push_back({64'h7FFF8, ww0});
    exp_wd_q.push_back({64'h0, ww1});
    send_cmd(8'h40, 16'hFFFF, 16'd2);
    send_word(ww0, BYTES_D);
    send_word(ww1, BYTES_D);
    wait_idle("wrap_idle");

    repeat (5) @(posedge clk);
    #1;
    check("wi_left", 128'(exp_wi_q.size()), 128'd0);
    check("wd_left", 128'(exp_wd_q.size()), 128'd0);
    check("tx_left", 128'(exp_tx_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
